// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: load width/sign codes, write-back FSM states
// and datapath constants.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LH  = 3'b001,
    LT_LHU = 3'b010,
    LT_LB  = 3'b011,
    LT_LBU = 3'b100
  } load_type_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LD,
    COMMIT
  } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Combinational load-data aligner: picks the byte/half lane of a little-endian
// word and sign- or zero-extends it. Unknown load codes pass the word through.
module load_extend
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] raw,
  input  logic [2:0]        load_type,
  input  logic [1:0]        byte_off,
  output logic [DATA_W-1:0] ext
);

  function automatic logic [DATA_W-1:0] sext8(input logic signed [7:0] v);
    return DATA_W'(v);
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic signed [15:0] v);
    return DATA_W'(v);
  endfunction

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = byte_off[1] ? raw[31:16] : raw[15:0];
    byte_sel = raw[{byte_off, 3'b000} +: 8];
    case (load_type)
      LT_LH:   ext = sext16(half_sel);
      LT_LHU:  ext = DATA_W'(half_sel);
      LT_LB:   ext = sext8(byte_sel);
      LT_LBU:  ext = DATA_W'(byte_sel);
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Write-back stage: sole driver of the register-file write port; waits for
// load data and commits one registered write per instruction.
// Optional WB_RETIRE_CNT_EN adds a 32-bit retire counter output.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [2:0]        in_load_type,
  input  logic [1:0]        in_byte_off,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  import mips_pkg::*;

  wb_state_e         state;
  logic              accept;
  logic [ADDR_W-1:0] rd_p0;
  logic              rw_p0;
  logic [2:0]        lt_p0;
  logic [1:0]        off_p0;
  logic [DATA_W-1:0] ld_ext;

  assign in_ready = (state == IDLE) || (state == COMMIT);
  assign accept   = in_valid && in_ready;

  // Load context held while the data memory answers; data only, no reset.
  always_ff @(posedge clk) begin
    if (accept && in_mem_to_reg) begin
      rd_p0  <= in_rd;
      rw_p0  <= in_reg_write;
      lt_p0  <= in_load_type;
      off_p0 <= in_byte_off;
    end
  end

  load_extend u_load_extend (
    .raw       (dmem_rdata),
    .load_type (lt_p0),
    .byte_off  (off_p0),
    .ext       (ld_ext)
  );

  // Commit stage: write port is loaded on the edge that enters COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy     <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        IDLE, COMMIT: begin
          if (accept) begin
            if (in_mem_to_reg) begin
              state <= WAIT_LD;
              busy  <= 1'b1;
            end else begin
              state    <= COMMIT;
              rf_we    <= in_reg_write && (in_rd != ADDR_W'(REG_ZERO));
              rf_waddr <= in_rd;
              rf_wdata <= in_alu_result;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT_LD: begin
          if (dmem_rvalid) begin
            state    <= COMMIT;
            busy     <= 1'b0;
            rf_we    <= rw_p0 && (rd_p0 != ADDR_W'(REG_ZERO));
            rf_waddr <= rd_p0;
            rf_wdata <= ld_ext;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Counts every commit, including suppressed writes; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= 32'd0;
    end else if (state == COMMIT) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule
